// File: rtl/cv32e40px_register_file_sb_if.sv
// Bus bundle for cv32e40px_register_file_sb: read ports, core/X writeback ports
// and the offload issue / scoreboard status signals.
interface cv32e40px_register_file_sb_if #(
  parameter int ADDR_WIDTH  = 6,
  parameter int DATA_WIDTH  = 32,
  parameter int N_READ      = 3,
  parameter int X_DUALWRITE = 0
);

  logic [N_READ-1:0][ADDR_WIDTH-1:0]      raddr_i;
  logic [N_READ-1:0][DATA_WIDTH-1:0]      rdata_o;
  logic [N_READ-1:0]                      busy_o;

  logic [ADDR_WIDTH-1:0]                  waddr_a_i;
  logic [DATA_WIDTH-1:0]                  wdata_a_i;
  logic                                   we_a_i;

  logic [ADDR_WIDTH-1:0]                  waddr_b_i;
  logic [X_DUALWRITE:0][DATA_WIDTH-1:0]   wdata_b_i;
  logic [X_DUALWRITE:0]                   we_b_i;

  logic                                   issue_valid_i;
  logic [ADDR_WIDTH-1:0]                  issue_rd_i;
  logic                                   issue_dual_i;
  logic                                   issue_ready_o;

  logic                                   sb_err_o;
  logic                                   idle_o;

  modport master (
    output raddr_i, waddr_a_i, wdata_a_i, we_a_i,
           waddr_b_i, wdata_b_i, we_b_i,
           issue_valid_i, issue_rd_i, issue_dual_i,
    input  rdata_o, busy_o, issue_ready_o, sb_err_o, idle_o
  );

  modport slave (
    input  raddr_i, waddr_a_i, wdata_a_i, we_a_i,
           waddr_b_i, wdata_b_i, we_b_i,
           issue_valid_i, issue_rd_i, issue_dual_i,
    output rdata_o, busy_o, issue_ready_o, sb_err_o, idle_o
  );

endinterface

// File: rtl/cv32e40px_register_file_sb.sv
// Flip-flop register file with per-register outstanding-result scoreboard.
// Define CV32E40PX_RF_BYPASS_EN to forward same-cycle writes/retires to the outputs.
module cv32e40px_register_file_sb #(
  parameter int ADDR_WIDTH  = 6,
  parameter int DATA_WIDTH  = 32,
  parameter int FPU         = 0,
  parameter int ZFINX       = 0,
  parameter int N_READ      = 3,
  parameter int X_DUALWRITE = 0,
  parameter int SB_CNT_W    = 2
) (
  input logic                         clk,
  input logic                         rst,
  cv32e40px_register_file_sb_if.slave bus
);

  localparam int                  NREG    = 1 << ADDR_WIDTH;
  localparam bit                  FP_EN   = (FPU != 0) && (ZFINX == 0);
  localparam logic [SB_CNT_W-1:0] CNT_MAX = '1;

  logic [DATA_WIDTH-1:0] mem [NREG];
  logic [SB_CNT_W-1:0]   cnt [NREG];
  logic                  sb_err_q;
  logic                  idle_q;

  // x0 and the absent FP bank have no storage and no counter
  function automatic logic reg_exists(input logic [ADDR_WIDTH-1:0] a);
    reg_exists = (a != '0) && (!a[ADDR_WIDTH-1] || FP_EN);
  endfunction

  logic [ADDR_WIDTH-1:0] waddr_b_hi;
  logic [ADDR_WIDTH-1:0] issue_hi;
  logic                  wr_a;
  logic                  wr_b0;
  logic                  wr_b1;
  logic                  pair_odd;
  logic [DATA_WIDTH-1:0] wdata_b_hi;

  assign waddr_b_hi = {bus.waddr_b_i[ADDR_WIDTH-1:1], 1'b1};
  assign issue_hi   = {bus.issue_rd_i[ADDR_WIDTH-1:1], 1'b1};
  assign wr_a       = bus.we_a_i && reg_exists(bus.waddr_a_i);
  assign wr_b0      = bus.we_b_i[0] && reg_exists(bus.waddr_b_i);

  generate
    if (X_DUALWRITE != 0) begin : g_dual
      assign wr_b1      = bus.we_b_i[1] && !bus.waddr_b_i[0] && reg_exists(waddr_b_hi);
      assign pair_odd   = bus.we_b_i[1] && bus.waddr_b_i[0];
      assign wdata_b_hi = bus.wdata_b_i[1];
    end else begin : g_single
      assign wr_b1      = 1'b0;
      assign pair_odd   = 1'b0;
      assign wdata_b_hi = '0;
    end
  endgenerate

  logic [NREG-1:0] hit_a;
  logic [NREG-1:0] hit_b0;
  logic [NREG-1:0] hit_b1;
  logic [NREG-1:0] dec;
  logic [NREG-1:0] dec_byp;
  logic [NREG-1:0] inc;

  always_comb begin
    hit_a  = '0;
    hit_b0 = '0;
    hit_b1 = '0;
    dec    = '0;
    for (int i = 0; i < NREG; i++) begin
      hit_a[i]  = wr_a  && (bus.waddr_a_i == ADDR_WIDTH'(i));
      hit_b0[i] = wr_b0 && (bus.waddr_b_i == ADDR_WIDTH'(i));
      hit_b1[i] = wr_b1 && (waddr_b_hi == ADDR_WIDTH'(i));
      dec[i]    = (hit_b0[i] || hit_b1[i]) && (cnt[i] != '0);
    end
  end

`ifdef CV32E40PX_RF_BYPASS_EN
  assign dec_byp = dec;
`else
  assign dec_byp = '0;
`endif

  logic issue_dual_ok;
  logic full_lo;
  logic full_hi;
  logic issue_ready;
  logic accept;
  logic any_busy;
  logic err_next;

  // A dual issue on an odd rd degrades to a single issue on rd
  assign issue_dual_ok = bus.issue_dual_i && !bus.issue_rd_i[0];
  assign full_lo = reg_exists(bus.issue_rd_i) && (cnt[bus.issue_rd_i] == CNT_MAX)
                   && !dec_byp[bus.issue_rd_i];
  assign full_hi = issue_dual_ok && reg_exists(issue_hi) && (cnt[issue_hi] == CNT_MAX)
                   && !dec_byp[issue_hi];
  assign issue_ready = !(full_lo || full_hi);
  assign accept      = bus.issue_valid_i && issue_ready;

  always_comb begin
    inc      = '0;
    any_busy = 1'b0;
    for (int i = 0; i < NREG; i++) begin
      inc[i] = accept && reg_exists(ADDR_WIDTH'(i)) &&
               ((bus.issue_rd_i == ADDR_WIDTH'(i)) ||
                (issue_dual_ok && (issue_hi == ADDR_WIDTH'(i))));
      any_busy = any_busy || (cnt[i] != '0);
    end
  end

  assign err_next = (wr_b0 && (cnt[bus.waddr_b_i] == '0)) ||
                    (wr_b1 && (cnt[waddr_b_hi] == '0)) ||
                    pair_odd ||
                    (accept && bus.issue_dual_i && bus.issue_rd_i[0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        mem[i] <= '0;
        cnt[i] <= '0;
      end
      sb_err_q <= 1'b0;
      idle_q   <= 1'b1;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (hit_b1[i]) begin
          mem[i] <= wdata_b_hi;
        end else if (hit_b0[i]) begin
          mem[i] <= bus.wdata_b_i[0];
        end else if (hit_a[i]) begin
          mem[i] <= bus.wdata_a_i;
        end
        cnt[i] <= cnt[i] + SB_CNT_W'(inc[i]) - SB_CNT_W'(dec[i]);
      end
      sb_err_q <= err_next;
      idle_q   <= !any_busy;
    end
  end

  logic [N_READ-1:0][DATA_WIDTH-1:0] rdata;
  logic [N_READ-1:0]                 busy;

  always_comb begin
    rdata = '0;
    busy  = '0;
    for (int k = 0; k < N_READ; k++) begin
      rdata[k] = mem[bus.raddr_i[k]];
`ifdef CV32E40PX_RF_BYPASS_EN
      if (hit_b1[bus.raddr_i[k]]) begin
        rdata[k] = wdata_b_hi;
      end else if (hit_b0[bus.raddr_i[k]]) begin
        rdata[k] = bus.wdata_b_i[0];
      end else if (hit_a[bus.raddr_i[k]]) begin
        rdata[k] = bus.wdata_a_i;
      end
`endif
      busy[k] = (cnt[bus.raddr_i[k]] - SB_CNT_W'(dec_byp[bus.raddr_i[k]])) != '0;
    end
  end

  assign bus.rdata_o       = rdata;
  assign bus.busy_o        = busy;
  assign bus.issue_ready_o = issue_ready;
  assign bus.sb_err_o      = sb_err_q;
  assign bus.idle_o        = idle_q;

endmodule

// File: tb/tb_cv32e40px_register_file_sb.sv
// Testbench for cv32e40px_register_file_sb: directed scenarios plus randomized
// traffic, compared every cycle against a behavioural register/scoreboard model.
module tb_cv32e40px_register_file_sb;

  localparam int AW   = 6;
  localparam int DW   = 32;
  localparam int NR   = 3;
  localparam int CW   = 2;
  localparam int MAXC = (1 << CW) - 1;
  localparam bit FP_EN = 1'b1;

  logic clk;
  logic rst;

  cv32e40px_register_file_sb_if #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .N_READ(NR), .X_DUALWRITE(1)
  ) bus ();

  cv32e40px_register_file_sb #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FPU(1), .ZFINX(0),
    .N_READ(NR), .X_DUALWRITE(1), .SB_CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] m_mem [64];
  logic [DW-1:0] n_mem [64];
  int            m_cnt [64];
  int            n_cnt [64];
  int            d_cnt [64];
  bit            m_err, m_idle, n_err, n_idle;
  bit            exp_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit exists(input int a);
    return (a != 0) && (a < 32 || FP_EN);
  endfunction

  task automatic applyStimulus(input logic iv, input int ird, input logic idual,
                               input logic wea, input int waa, input logic [31:0] wda,
                               input logic [1:0] web, input int wab,
                               input logic [31:0] wdb0, input logic [31:0] wdb1);
    bus.issue_valid_i = iv;
    bus.issue_rd_i    = AW'(ird);
    bus.issue_dual_i  = idual;
    bus.we_a_i        = wea;
    bus.waddr_a_i     = AW'(waa);
    bus.wdata_a_i     = wda;
    bus.we_b_i        = web;
    bus.waddr_b_i     = AW'(wab);
    bus.wdata_b_i[0]  = wdb0;
    bus.wdata_b_i[1]  = wdb1;
  endtask

  task automatic clearInputs();
    applyStimulus(1'b0, 0, 1'b0, 1'b0, 0, 32'h0, 2'b00, 0, 32'h0, 32'h0);
  endtask

  task automatic setReads(input int r0, input int r1, input int r2);
    bus.raddr_i[0] = AW'(r0);
    bus.raddr_i[1] = AW'(r1);
    bus.raddr_i[2] = AW'(r2);
  endtask

  task automatic resetModel();
    for (int i = 0; i < 64; i++) begin
      m_mem[i] = '0;
      m_cnt[i] = 0;
    end
    m_err  = 1'b0;
    m_idle = 1'b1;
  endtask

  // Evaluate the model for the inputs currently driven and compare all outputs
  task automatic checkNow();
    int            wa[$];
    logic [DW-1:0] wd[$];
    int            tg[$];
    bit            err;
    bit            dual_odd;
    int            ird, wab, ra, lvl;
    logic [DW-1:0] exp_rd;
    @(negedge clk);
    err      = 1'b0;
    dual_odd = 1'b0;
    n_mem    = m_mem;
    n_cnt    = m_cnt;
    d_cnt    = m_cnt;
    ird      = int'(bus.issue_rd_i);
    wab      = int'(bus.waddr_b_i);
    if (bus.we_a_i && exists(int'(bus.waddr_a_i))) n_mem[int'(bus.waddr_a_i)] = bus.wdata_a_i;
    if (bus.we_b_i[0] && exists(wab)) begin
      wa.push_back(wab);
      wd.push_back(bus.wdata_b_i[0]);
    end
    if (bus.we_b_i[1]) begin
      if (wab % 2 == 1) err = 1'b1;
      else if (exists(wab + 1)) begin
        wa.push_back(wab + 1);
        wd.push_back(bus.wdata_b_i[1]);
      end
    end
    foreach (wa[j]) begin
      n_mem[wa[j]] = wd[j];
      if (m_cnt[wa[j]] == 0) err = 1'b1;
      else begin
        n_cnt[wa[j]]--;
        d_cnt[wa[j]]--;
      end
    end
    if (exists(ird)) tg.push_back(ird);
    if (bus.issue_dual_i) begin
      if (ird % 2 == 1) dual_odd = 1'b1;
      else if (exists(ird + 1)) tg.push_back(ird + 1);
    end
    exp_ready = 1'b1;
    foreach (tg[j]) begin
`ifdef CV32E40PX_RF_BYPASS_EN
      lvl = d_cnt[tg[j]];
`else
      lvl = m_cnt[tg[j]];
`endif
      if (lvl == MAXC) exp_ready = 1'b0;
    end
    if (bus.issue_valid_i && exp_ready) begin
      foreach (tg[j]) n_cnt[tg[j]]++;
      if (dual_odd) err = 1'b1;
    end
    n_err  = err;
    n_idle = 1'b1;
    for (int i = 0; i < 64; i++) if (m_cnt[i] != 0) n_idle = 1'b0;

    for (int k = 0; k < NR; k++) begin
      ra = int'(bus.raddr_i[k]);
`ifdef CV32E40PX_RF_BYPASS_EN
      exp_rd = n_mem[ra];
      lvl    = d_cnt[ra];
`else
      exp_rd = m_mem[ra];
      lvl    = m_cnt[ra];
`endif
      checkOutput($sformatf("rdata%0d_a%0d", k, ra), bus.rdata_o[k], exp_rd);
      checkOutput($sformatf("busy%0d_a%0d", k, ra), bus.busy_o[k], (lvl != 0));
    end
    checkOutput("issue_ready", bus.issue_ready_o, exp_ready);
    checkOutput("sb_err", bus.sb_err_o, m_err);
    checkOutput("idle", bus.idle_o, m_idle);

    if (rst) begin
      for (int i = 0; i < 64; i++) begin
        n_mem[i] = '0;
        n_cnt[i] = 0;
      end
      n_err  = 1'b0;
      n_idle = 1'b1;
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    m_mem  = n_mem;
    m_cnt  = n_cnt;
    m_err  = n_err;
    m_idle = n_idle;
  endtask

  task automatic cycle();
    checkNow();
    advance();
  endtask

  function automatic int pickAddr();
    int r;
    r = $urandom_range(0, 13);
    return (r < 8) ? r : 24 + r;
  endfunction

  initial begin
    rst = 1'b1;
    clearInputs();
    setReads(0, 0, 0);
    resetModel();
    repeat (2) cycle();
    rst = 1'b0;

    // Reset state, integer and FP reads
    setReads(5, 35, 0);
    checkNow();
    checkOutput("rst_rdata_x5", bus.rdata_o[0], 0);
    checkOutput("rst_rdata_f3", bus.rdata_o[1], 0);
    checkOutput("rst_busy", bus.busy_o, 0);
    checkOutput("rst_idle", bus.idle_o, 1);
    checkOutput("rst_ready", bus.issue_ready_o, 1);
    advance();

    // Fill x7 to the counter limit, then retire three results
    setReads(7, 0, 0);
    repeat (3) begin
      applyStimulus(1'b1, 7, 1'b0, 1'b0, 0, 0, 2'b00, 0, 0, 0);
      cycle();
    end
    applyStimulus(1'b1, 7, 1'b0, 1'b0, 0, 0, 2'b00, 0, 0, 0);
    checkNow();
    checkOutput("x7_fourth_ready", bus.issue_ready_o, 0);
    checkOutput("x7_full_busy", bus.busy_o[0], 1);
    advance();
    for (int j = 0; j < 3; j++) begin
      applyStimulus(1'b0, 0, 1'b0, 1'b0, 0, 0, 2'b01, 7, 32'hA5A5_0001, 0);
      cycle();
    end
    clearInputs();
    checkNow();
    checkOutput("x7_busy_clear", bus.busy_o[0], 0);
    checkOutput("x7_data", bus.rdata_o[0], 32'hA5A5_0001);
    checkOutput("x7_idle_lag", bus.idle_o, 0);
    checkOutput("x7_no_err", bus.sb_err_o, 0);
    advance();
    checkNow();
    checkOutput("x7_idle_set", bus.idle_o, 1);
    advance();

    // Dual issue and pair writeback, then an odd pair write
    setReads(10, 11, 12);
    applyStimulus(1'b1, 10, 1'b1, 1'b0, 0, 0, 2'b00, 0, 0, 0);
    cycle();
    applyStimulus(1'b0, 0, 1'b0, 1'b0, 0, 0, 2'b11, 10, 32'h1111_1111, 32'h2222_2222);
    cycle();
    clearInputs();
    checkNow();
    checkOutput("pair_x10", bus.rdata_o[0], 32'h1111_1111);
    checkOutput("pair_x11", bus.rdata_o[1], 32'h2222_2222);
    checkOutput("pair_busy", bus.busy_o, 0);
    checkOutput("pair_no_err", bus.sb_err_o, 0);
    advance();
    applyStimulus(1'b1, 11, 1'b0, 1'b0, 0, 0, 2'b00, 0, 0, 0);
    cycle();
    applyStimulus(1'b0, 0, 1'b0, 1'b0, 0, 0, 2'b11, 11, 32'h3333_3333, 32'h4444_4444);
    cycle();
    clearInputs();
    checkNow();
    checkOutput("odd_pair_x11", bus.rdata_o[1], 32'h3333_3333);
    checkOutput("odd_pair_x12", bus.rdata_o[2], 0);
    checkOutput("odd_pair_err", bus.sb_err_o, 1);
    advance();
    checkNow();
    checkOutput("odd_pair_err_pulse", bus.sb_err_o, 0);
    advance();

    // Port B beats port A; unexpected writeback still lands
    setReads(4, 9, 0);
    applyStimulus(1'b0, 0, 1'b0, 1'b1, 4, 32'hDEAD, 2'b01, 4, 32'hBEEF, 0);
    cycle();
    clearInputs();
    checkNow();
    checkOutput("prio_x4", bus.rdata_o[0], 32'hBEEF);
    checkOutput("prio_err", bus.sb_err_o, 1);
    advance();
    applyStimulus(1'b0, 0, 1'b0, 1'b0, 0, 0, 2'b01, 9, 32'h99, 0);
    cycle();
    clearInputs();
    checkNow();
    checkOutput("idle_wb_x9", bus.rdata_o[1], 32'h99);
    checkOutput("idle_wb_err", bus.sb_err_o, 1);
    advance();

    // Issue and retire on x3 in the same cycle
    setReads(3, 0, 0);
    applyStimulus(1'b1, 3, 1'b0, 1'b0, 0, 0, 2'b00, 0, 0, 0);
    cycle();
    applyStimulus(1'b1, 3, 1'b0, 1'b0, 0, 0, 2'b01, 3, 32'h3333, 0);
    checkNow();
`ifdef CV32E40PX_RF_BYPASS_EN
    checkOutput("x3_bypass_data", bus.rdata_o[0], 32'h3333);
`endif
    advance();
    clearInputs();
    checkNow();
    checkOutput("x3_still_busy", bus.busy_o[0], 1);
    checkOutput("x3_no_err", bus.sb_err_o, 0);
    advance();
    applyStimulus(1'b0, 0, 1'b0, 1'b0, 0, 0, 2'b01, 3, 32'h3334, 0);
    cycle();
    clearInputs();
    checkNow();
    checkOutput("x3_busy_clear", bus.busy_o[0], 0);
    checkOutput("x3_retire_no_err", bus.sb_err_o, 0);
    advance();

    // Reset with x2 busy, then a late writeback
    setReads(2, 0, 0);
    applyStimulus(1'b1, 2, 1'b0, 1'b1, 2, 32'h55, 2'b00, 0, 0, 0);
    cycle();
    clearInputs();
    checkNow();
    checkOutput("x2_data", bus.rdata_o[0], 32'h55);
    checkOutput("x2_busy", bus.busy_o[0], 1);
    advance();
    rst = 1'b1;
    resetModel();
    checkNow();
    checkOutput("x2_rst_data", bus.rdata_o[0], 0);
    checkOutput("x2_rst_busy", bus.busy_o[0], 0);
    checkOutput("x2_rst_idle", bus.idle_o, 1);
    checkOutput("x2_rst_ready", bus.issue_ready_o, 1);
    advance();
    rst = 1'b0;
    applyStimulus(1'b0, 0, 1'b0, 1'b0, 0, 0, 2'b01, 2, 32'h77, 0);
    cycle();
    clearInputs();
    checkNow();
    checkOutput("late_wb_err", bus.sb_err_o, 1);
    checkOutput("late_wb_data", bus.rdata_o[0], 32'h77);
    advance();

    // Randomized traffic on a small address pool to provoke collisions
    for (int n = 0; n < 800; n++) begin
      setReads(pickAddr(), pickAddr(), pickAddr());
      if ($urandom_range(0, 99) == 0) begin
        clearInputs();
        rst = 1'b1;
        resetModel();
        cycle();
        rst = 1'b0;
      end else begin
        applyStimulus($urandom_range(0, 1) == 1, pickAddr(), $urandom_range(0, 9) < 3,
                      $urandom_range(0, 9) < 4, pickAddr(), $urandom(),
                      {($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 4)},
                      pickAddr(), $urandom(), $urandom());
        cycle();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
